score_display: RTL and testbench

//  Downstream consumer of the game-control block's game_state and obs_left outputs.

---
 rtl/score_display.sv | 249 ++++++++++++++++++++++++
 tb/tb_score_display.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display
//   Keeps the run score as a 4-digit BCD counter and drives a multiplexed
//   4-digit 7-segment display. Sits downstream of the game-control block and
//   follows its game_state / obs_left outputs.
//   Score and blink logic advance only on the frame strobe, which is the
//   rising edge of clk24Hz sampled in the clk120kHz domain.
//
//   Optional feature macro: SCORE_HISCORE_EN
//     When defined, a BCD high-score register is kept. IDLE shows the high score,
//     and the OVER blank phase after a new record shows the units digit with dp
//     lit. When undefined, IDLE shows the last score and the OVER blink is a
//     full blank.
//
// Ports
//   clk120kHz   in   1   system clock
//   rstn        in   1   asynchronous, active-low reset
//   clk24Hz     in   1   frame clock (sampled)
//   game_state  in   2   0=init, 1=playing, 3=over, 2 treated as init
//   obs_left    in   16  obstacle x position; a rightward jump marks a pass
//   score_bcd   out  16  score {thousands,hundreds,tens,units}
//   seg         out  8   {dp,g,f,e,d,c,b,a}, active-low
//   an          out  4   digit enables, active-low one-hot, an[0] = units
//
// state | meaning
// IDLE  | waiting for play; score held, display static
// RUN   | scoring on distance and obstacle passes
// OVER  | score frozen, display blinks
module score_display #(
  parameter int FRAMES_PER_POINT = 6,
  parameter int PASS_BONUS       = 5,
  parameter int SCAN_DIV         = 120,
  parameter int BLINK_FRAMES     = 12
) (
  input  logic        clk120kHz,
  input  logic        rstn,
  input  logic        clk24Hz,
  input  logic [1:0]  game_state,
  input  logic [15:0] obs_left,
  output logic [15:0] score_bcd,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int FCW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  state_t         state, state_nxt;
  logic           clk24_q;
  logic           frame_stb;
  logic [FCW-1:0] frame_cnt;
  logic [15:0]    prev_obs;
  logic [BCW-1:0] blink_cnt;
  logic           blank_phase;
  logic [SCW-1:0] scan_cnt;
  logic [1:0]     digit_idx;
  logic           point, pass;
  logic [3:0]     add_amt;
  logic [16:0]    sum;
  logic [15:0]    disp_val;
  logic [3:0]     cur_digit;
  logic           lead_zero;
  logic [3:0]     an_nxt;
  logic [7:0]     seg_nxt;
`ifdef SCORE_HISCORE_EN
  logic [15:0]    hi_score;
  logic           new_rec;
`endif

  // Active-low segment patterns with dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Decimal add of a small amount (0..15) with ripple carry; bit 16 is carry out.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] amt);
    logic [15:0] addend;
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    addend = (amt > 4'd9) ? {8'd0, 4'd1, 4'(amt - 4'd10)} : {12'd0, amt};
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return {c, r};
  endfunction

  always_ff @(posedge clk120kHz or negedge rstn) begin
    if (!rstn) clk24_q <= 1'b0;
    else       clk24_q <= clk24Hz;
  end
  assign frame_stb = clk24Hz & ~clk24_q;

  // FSM: state register
  always_ff @(posedge clk120kHz or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (frame_stb) begin
      case (state)
        IDLE:    if (game_state == 2'd1) state_nxt = RUN;
        RUN:     if (game_state == 2'd3) state_nxt = OVER;
                 else if (game_state != 2'd1) state_nxt = IDLE;
        OVER:    if (game_state != 2'd3) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign point   = (frame_cnt == FCW'(FRAMES_PER_POINT - 1));
  assign pass    = (obs_left > prev_obs);
  assign add_amt = (point ? 4'd1 : 4'd0) + (pass ? 4'(PASS_BONUS) : 4'd0);
  assign sum     = bcd_add(score_bcd, add_amt);

  // Score, frame, blink and high-score datapath.
  always_ff @(posedge clk120kHz or negedge rstn) begin
    if (!rstn) begin
      score_bcd   <= '0;
      frame_cnt   <= '0;
      prev_obs    <= '0;
      blink_cnt   <= '0;
      blank_phase <= 1'b0;
`ifdef SCORE_HISCORE_EN
      hi_score    <= '0;
      new_rec     <= 1'b0;
`endif
    end else if (frame_stb) begin
      case (state)
        IDLE: begin
          if (state_nxt == RUN) begin
            score_bcd <= '0;
            frame_cnt <= '0;
            prev_obs  <= obs_left;
          end
        end
        RUN: begin
          if (state_nxt == RUN) begin
            frame_cnt <= point ? '0 : frame_cnt + 1'b1;
            prev_obs  <= obs_left;
            score_bcd <= sum[16] ? 16'h9999 : sum[15:0];
          end else if (state_nxt == OVER) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
`ifdef SCORE_HISCORE_EN
            // BCD ordering matches binary ordering, so a plain compare works.
            new_rec <= (score_bcd > hi_score);
            if (score_bcd > hi_score) hi_score <= score_bcd;
`endif
          end
        end
        OVER: begin
          if (state_nxt == OVER) begin
            if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
              blink_cnt   <= '0;
              blank_phase <= ~blank_phase;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end else begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit scan runs free, independent of the blink phase.
  always_ff @(posedge clk120kHz or negedge rstn) begin
    if (!rstn) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // FSM: outputs (display drive)
  always_comb begin
    disp_val = score_bcd;
`ifdef SCORE_HISCORE_EN
    if (state == IDLE) disp_val = hi_score;
`endif
    cur_digit = disp_val[{digit_idx, 2'b00} +: 4];
    case (digit_idx)
      2'd3:    lead_zero = (disp_val[15:12] == 4'd0);
      2'd2:    lead_zero = (disp_val[15:8]  == 8'd0);
      2'd1:    lead_zero = (disp_val[15:4]  == 12'd0);
      default: lead_zero = 1'b0;
    endcase
    an_nxt  = ~(4'b0001 << digit_idx);
    seg_nxt = lead_zero ? 8'hFF : seg7(cur_digit);
    if (state == OVER && blank_phase) begin
`ifdef SCORE_HISCORE_EN
      if (new_rec && digit_idx == 2'd0) begin
        seg_nxt = seg7(disp_val[3:0]) & 8'h7F;
      end else begin
        an_nxt  = 4'hF;
        seg_nxt = 8'hFF;
      end
`else
      an_nxt  = 4'hF;
      seg_nxt = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk120kHz or negedge rstn) begin
    if (!rstn) begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int SCAN_DIV = 120;
`ifdef SCORE_HISCORE_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic        clk120kHz;
  logic        rstn;
  logic        clk24Hz;
  logic [1:0]  game_state;
  logic [15:0] obs_left;
  logic [15:0] score_bcd;
  logic [7:0]  seg;
  logic [3:0]  an;

  score_display dut (
    .clk120kHz (clk120kHz),
    .rstn      (rstn),
    .clk24Hz   (clk24Hz),
    .game_state(game_state),
    .obs_left  (obs_left),
    .score_bcd (score_bcd),
    .seg       (seg),
    .an        (an)
  );

  initial clk120kHz = 1'b0;
  always #5 clk120kHz = ~clk120kHz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  seg_tbl[10];
  logic [7:0]  cap_seg[4];

  // Reference model state (integer arithmetic)
  int m_st, m_score, m_fc, m_prev, m_bcnt, m_hi;
  bit m_blank, m_rec;
  int cur_obs;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int pow10(input int i);
    case (i)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int i, input int v);
    int d;
    d = (v / pow10(i)) % 10;
    if (i > 0 && v < pow10(i)) return 8'hFF;
    return seg_tbl[d];
  endfunction

  task automatic model_step(input int gs, input int obs);
    int add;
    case (m_st)
      0: if (gs == 1) begin m_st = 1; m_score = 0; m_fc = 0; m_prev = obs; end
      1: begin
        if (gs == 3) begin
          m_st = 2; m_bcnt = 0; m_blank = 0;
          m_rec = (m_score > m_hi);
          if (m_score > m_hi) m_hi = m_score;
        end else if (gs != 1) begin
          m_st = 0;
        end else begin
          add = 0;
          if (m_fc == 5) begin m_fc = 0; add += 1; end
          else m_fc++;
          if (obs > m_prev) add += 5;
          m_prev = obs;
          m_score = (m_score + add > 9999) ? 9999 : m_score + add;
        end
      end
      default: begin
        if (gs != 3) begin
          m_st = 0; m_blank = 0;
        end else if (m_bcnt == 11) begin
          m_bcnt = 0; m_blank = !m_blank;
        end else begin
          m_bcnt++;
        end
      end
    endcase
  endtask

  // One frame: drive inputs, push expected score, pulse clk24Hz, pop and compare.
  task automatic strobe(input int gs, input int obs);
    logic [15:0] e;
    @(negedge clk120kHz);
    game_state = 2'(gs);
    obs_left   = 16'(obs);
    model_step(gs, obs);
    exp_q.push_back(to_bcd(m_score));
    clk24Hz = 1'b1;
    @(negedge clk120kHz);
    clk24Hz = 1'b0;
    @(negedge clk120kHz);
    e = exp_q.pop_front();
    chk("score", score_bcd, e);
  endtask

  task automatic pass_strobe(input int gs);
    cur_obs++;
    strobe(gs, cur_obs);
  endtask

  task automatic reach(input int target);
    int guard;
    guard = 0;
    while (m_score != target && guard < 300) begin
      if (target - m_score >= 6) pass_strobe(1);
      else strobe(1, cur_obs);
      guard++;
    end
    chk("reach_target", to_bcd(m_score), to_bcd(target));
  endtask

  // Watch one full scan and compare what each digit showed with the model.
  task automatic check_disp(input string tag);
    int seen[4];
    int nblank, nbad, v;
    for (int i = 0; i < 4; i++) begin seen[i] = 0; cap_seg[i] = 8'h00; end
    nblank = 0; nbad = 0;
    for (int c = 0; c < 4 * SCAN_DIV + 4; c++) begin
      @(negedge clk120kHz);
      case (an)
        4'hE: begin seen[0]++; cap_seg[0] = seg; end
        4'hD: begin seen[1]++; cap_seg[1] = seg; end
        4'hB: begin seen[2]++; cap_seg[2] = seg; end
        4'h7: begin seen[3]++; cap_seg[3] = seg; end
        4'hF: nblank++;
        default: nbad++;
      endcase
    end
    chk($sformatf("%s_an_onehot", tag), 16'(nbad), 16'd0);
    v = (HI && m_st == 0) ? m_hi : m_score;
    if (m_st == 2 && m_blank) begin
      if (HI && m_rec) begin
        chk($sformatf("%s_rec_units", tag), {8'd0, cap_seg[0]}, {8'd0, seg_tbl[v % 10] & 8'h7F});
        chk($sformatf("%s_rec_others", tag), 16'(seen[1] + seen[2] + seen[3]), 16'd0);
      end else begin
        chk($sformatf("%s_blank", tag), 16'(seen[0] + seen[1] + seen[2] + seen[3]), 16'd0);
      end
    end else begin
      chk($sformatf("%s_noblank", tag), 16'(nblank), 16'd0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_d%0d", tag, i), {8'd0, cap_seg[i]}, {8'd0, exp_seg(i, v)});
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_score = 0; m_fc = 0; m_prev = 0; m_bcnt = 0; m_hi = 0;
    m_blank = 0; m_rec = 0;
  endtask

  initial begin
    logic [3:0] an_exp[5];
    seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    model_reset();
    cur_obs    = 100;
    rstn       = 1'b0;
    clk24Hz    = 1'b0;
    game_state = 2'd0;
    obs_left   = 16'd0;

    // T1 reset and scan order
    repeat (10) @(negedge clk120kHz);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_seg", {8'd0, seg}, 16'h00FF);
    rstn = 1'b1;
    for (int k = 1; k <= 540; k++) begin
      @(posedge clk120kHz);
      #1;
      if (k % 120 == 60) chk($sformatf("scan_an_k%0d", k), {12'd0, an}, {12'd0, an_exp[k / 120]});
      if (k == 60) chk("scan_units_zero", {8'd0, seg}, 16'h00C0);
    end
    check_disp("idle0");

    // T2 distance
    strobe(1, 100);
    for (int i = 0; i < 60; i++) strobe(1, 100);
    chk("t2_score", score_bcd, 16'h0010);
    check_disp("t2");

    // T3 pass coinciding with a point frame
    for (int i = 0; i < 5; i++) strobe(1, 10);
    strobe(1, 240);
    chk("t3_score", score_bcd, 16'h0016);
    cur_obs = 240;

    // T5 over and blink
    reach(42);
    strobe(3, cur_obs);
    chk("t5_frozen", score_bcd, 16'h0042);
    check_disp("t5_vis0");
    for (int s = 1; s <= 36; s++) begin
      pass_strobe(3);
      if (s == 11 || s == 12 || s == 23 || s == 24 || s == 35)
        check_disp($sformatf("t5_s%0d", s));
    end
    chk("t5_still_frozen", score_bcd, 16'h0042);
    strobe(0, cur_obs);
    check_disp("t5_idle");

    // T4 saturation
    strobe(1, cur_obs);
    begin
      int guard;
      guard = 0;
      while (m_score < 9990 && guard < 3000) begin pass_strobe(1); guard++; end
      guard = 0;
      while (m_score != 9997 && guard < 100) begin strobe(1, cur_obs); guard++; end
    end
    chk("t4_pre", score_bcd, 16'h9997);
    pass_strobe(1);
    chk("t4_sat", score_bcd, 16'h9999);
    for (int i = 0; i < 8; i++) pass_strobe(1);
    chk("t4_hold", score_bcd, 16'h9999);
    check_disp("t4");

    // Reset mid-run, no strobe needed
    @(negedge clk120kHz);
    rstn = 1'b0;
    #1;
    chk("midrst_score", score_bcd, 16'h0000);
    chk("midrst_an", {12'd0, an}, 16'h000F);
    chk("midrst_seg", {8'd0, seg}, 16'h00FF);
    model_reset();
    repeat (3) @(negedge clk120kHz);
    rstn = 1'b1;

    // T6 two runs: 30 then 20
    strobe(1, cur_obs);
    reach(30);
    strobe(3, cur_obs);
    strobe(0, cur_obs);
    strobe(1, cur_obs);
    reach(20);
    strobe(3, cur_obs);
    strobe(0, cur_obs);
    chk("t6_score_out", score_bcd, 16'h0020);
    check_disp("t6");
    chk("t6_tens", {8'd0, cap_seg[1]}, HI ? 16'h00B0 : 16'h00A4);
    chk("t6_units", {8'd0, cap_seg[0]}, 16'h00C0);

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
